// File: rtl/sid_ctrl_pkg.sv
// Shared types and widths for the sid8580 write front end.
// Reusable by any wrapper that drives the SID register port.
package sid_ctrl_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 8;
  localparam int SID_NUM_REGS = 25;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } seq_state_e;

endpackage

// File: rtl/sid_wr_fifo.sv
// Host write FIFO: power-of-two depth, first-word fall-through head.
// Full FIFO ignores push; empty FIFO ignores pop.
module sid_wr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 13,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/sid_write_sequencer.sv
// Merges CPU, host FIFO and zero-fill writes onto the SID write port.
// CPU wins every cycle; clear and FIFO writes are paced by ce_1m.
module sid_write_sequencer
  import sid_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_REGS   = SID_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_1m,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              clear,
  output logic              sid_we,
  output logic [ADDR_W-1:0] sid_addr,
  output logic [DATA_W-1:0] sid_data,
  output logic              busy
);

  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_head;

  sid_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host_valid),
    .wdata ({host_addr, host_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    fifo_pop  = 1'b0;
    if (cpu_we) begin
      we_d   = 1'b1;
      addr_d = cpu_addr;
      data_d = cpu_data;
    end else if (ce_1m && state_q == ST_CLEAR) begin
      we_d      = 1'b1;
      addr_d    = clr_idx_q;
      data_d    = '0;
      clr_idx_d = clr_idx_q + ADDR_W'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
      end
    end else if (ce_1m && !fifo_empty) begin
      we_d     = 1'b1;
      fifo_pop = 1'b1;
      addr_d   = fifo_head[FW-1:DATA_W];
      data_d   = fifo_head[DATA_W-1:0];
    end
    // A clear request always (re)starts the fill from register 0
    if (clear) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign host_ready = ~fifo_full;
  assign sid_we     = we_q;
  assign sid_data   = data_q;
  assign sid_addr   = we_q ? addr_q : cpu_addr;
  assign busy       = (state_q == ST_CLEAR) | (fifo_count != '0);

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Bench for sid_write_sequencer: CPU vector table plus scoreboarded
// FIFO, clear, collision and reset sequences.
module tb_sid_write_sequencer;

  logic       clk = 1'b0;
  logic       reset, ce_1m, cpu_we, host_valid, clear;
  logic [4:0] cpu_addr, host_addr;
  logic [7:0] cpu_data, host_data;
  logic       host_ready, sid_we, busy;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    logic [4:0] ea;
    logic [7:0] ed;
  } vec_t;

  wr_t  sb[$];
  wr_t  mon_e;
  vec_t vecs[6];

  always #5 clk = ~clk;

  sid_write_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ce_1m      (ce_1m),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .clear      (clear),
    .sid_we     (sid_we),
    .sid_addr   (sid_addr),
    .sid_data   (sid_data),
    .busy       (busy)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && sid_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=%h/%h required=none t=%0t",
                 sid_addr, sid_data, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_addr", {27'b0, sid_addr}, {27'b0, mon_e.a});
        chk("sb_data", {24'b0, sid_data}, {24'b0, mon_e.d});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      step();
      chk("idle_we", {31'b0, sid_we}, 32'd0);
    end
  endtask

  task automatic ce_write(input wr_t e);
    ce_1m = 1'b1;
    sb.push_back(e);
    step();
    ce_1m = 1'b0;
    chk("ce_we", {31'b0, sid_we}, 32'd1);
    chk("ce_addr", {27'b0, sid_addr}, {27'b0, e.a});
    chk("ce_data", {24'b0, sid_data}, {24'b0, e.d});
    step();
    chk("ce_gap_we", {31'b0, sid_we}, 32'd0);
  endtask

  task automatic host_push(input logic [4:0] a, input logic [7:0] d);
    chk("host_ready", {31'b0, host_ready}, 32'd1);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    step();
    host_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'h04, 8'h41, 5'h04, 8'h41};
    vecs[1] = '{5'h00, 8'h00, 5'h00, 8'h00};
    vecs[2] = '{5'h1F, 8'hFF, 5'h1F, 8'hFF};
    vecs[3] = '{5'h18, 8'hA5, 5'h18, 8'hA5};
    vecs[4] = '{5'h0B, 8'h3C, 5'h0B, 8'h3C};
    vecs[5] = '{5'h19, 8'h01, 5'h19, 8'h01};

    reset = 1'b1; ce_1m = 1'b0; cpu_we = 1'b0; host_valid = 1'b0;
    clear = 1'b0; cpu_addr = 5'h00; cpu_data = 8'h00;
    host_addr = 5'h00; host_data = 8'h00;
    repeat (3) step();
    chk("rst_we", {31'b0, sid_we}, 32'd0);
    chk("rst_data", {24'b0, sid_data}, 32'd0);
    chk("rst_ready", {31'b0, host_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // CPU passthrough table
    for (int i = 0; i < 6; i++) begin
      cpu_addr = vecs[i].a;
      cpu_data = vecs[i].d;
      cpu_we   = 1'b1;
      sb.push_back(wr_t'{vecs[i].ea, vecs[i].ed});
      step();
      cpu_we   = 1'b0;
      cpu_addr = 5'(i + 7);
      chk("cpu_we", {31'b0, sid_we}, 32'd1);
      chk("cpu_addr", {27'b0, sid_addr}, {27'b0, vecs[i].ea});
      chk("cpu_data", {24'b0, sid_data}, {24'b0, vecs[i].ed});
      step();
      chk("cpu_we_off", {31'b0, sid_we}, 32'd0);
      chk("addr_passthru", {27'b0, sid_addr}, 32'(i + 7));
    end

    // Back-to-back CPU writes
    cpu_we = 1'b1; cpu_addr = 5'h02; cpu_data = 8'hAA;
    sb.push_back(wr_t'{5'h02, 8'hAA});
    step();
    cpu_addr = 5'h03; cpu_data = 8'hBB;
    sb.push_back(wr_t'{5'h03, 8'hBB});
    chk("b2b_we0", {31'b0, sid_we}, 32'd1);
    chk("b2b_addr0", {27'b0, sid_addr}, 32'h02);
    step();
    cpu_we = 1'b0;
    chk("b2b_we1", {31'b0, sid_we}, 32'd1);
    chk("b2b_addr1", {27'b0, sid_addr}, 32'h03);
    chk("b2b_data1", {24'b0, sid_data}, 32'hBB);
    idle_chk(1);

    // FIFO fill and pacing
    host_push(5'h00, 8'h11);
    host_push(5'h01, 8'h22);
    host_push(5'h02, 8'h33);
    host_push(5'h03, 8'h44);
    chk("full_ready", {31'b0, host_ready}, 32'd0);
    chk("full_busy", {31'b0, busy}, 32'd1);
    idle_chk(3);
    ce_write(wr_t'{5'h00, 8'h11});
    chk("ready_after_pop", {31'b0, host_ready}, 32'd1);
    idle_chk(2);
    ce_write(wr_t'{5'h01, 8'h22});
    idle_chk(2);
    ce_write(wr_t'{5'h02, 8'h33});
    chk("busy_mid", {31'b0, busy}, 32'd1);
    ce_write(wr_t'{5'h03, 8'h44});
    chk("busy_drained", {31'b0, busy}, 32'd0);

    // CPU and FIFO collide on a ce_1m cycle
    host_push(5'h1E, 8'h55);
    cpu_we = 1'b1; cpu_addr = 5'h07; cpu_data = 8'h77; ce_1m = 1'b1;
    sb.push_back(wr_t'{5'h07, 8'h77});
    step();
    cpu_we = 1'b0; ce_1m = 1'b0;
    chk("coll_we", {31'b0, sid_we}, 32'd1);
    chk("coll_addr", {27'b0, sid_addr}, 32'h07);
    chk("coll_data", {24'b0, sid_data}, 32'h77);
    chk("coll_busy", {31'b0, busy}, 32'd1);
    idle_chk(2);
    ce_write(wr_t'{5'h1E, 8'h55});
    chk("coll_busy_end", {31'b0, busy}, 32'd0);

    // Full clear with host entries pushed mid-sequence
    pulse_clear();
    chk("clr_busy", {31'b0, busy}, 32'd1);
    idle_chk(2);
    for (int i = 0; i < 25; i++) begin
      ce_write(wr_t'{5'(i), 8'h00});
      if (i == 5) begin
        host_push(5'h1A, 8'h5A);
        host_push(5'h02, 8'h99);
      end
    end
    chk("clr_done_busy", {31'b0, busy}, 32'd1);
    ce_write(wr_t'{5'h1A, 8'h5A});
    ce_write(wr_t'{5'h02, 8'h99});
    chk("clr_fifo_busy", {31'b0, busy}, 32'd0);

    // Restart after 0x0A, then a CPU write preempts a clear slot
    pulse_clear();
    for (int i = 0; i <= 10; i++) ce_write(wr_t'{5'(i), 8'h00});
    pulse_clear();
    cpu_we = 1'b1; cpu_addr = 5'h11; cpu_data = 8'hC3; ce_1m = 1'b1;
    sb.push_back(wr_t'{5'h11, 8'hC3});
    step();
    cpu_we = 1'b0; ce_1m = 1'b0;
    chk("pre_we", {31'b0, sid_we}, 32'd1);
    chk("pre_addr", {27'b0, sid_addr}, 32'h11);
    step();
    for (int i = 0; i < 25; i++) ce_write(wr_t'{5'(i), 8'h00});
    chk("restart_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a clear with pending host entries
    pulse_clear();
    for (int i = 0; i < 3; i++) ce_write(wr_t'{5'(i), 8'h00});
    host_push(5'h05, 8'h01);
    host_push(5'h06, 8'h02);
    host_push(5'h07, 8'h03);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_we", {31'b0, sid_we}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, host_ready}, 32'd1);
    repeat (5) begin
      ce_1m = 1'b1;
      step();
      ce_1m = 1'b0;
      chk("post_rst_we", {31'b0, sid_we}, 32'd0);
      idle_chk(2);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sid_write_sequencer.md
# sid_write_sequencer

Single-writer front end for the sid8580 register file. Merges three write sources onto the SID's one-port write bus: the C64 CPU bus, a host-side injector behind a valid/ready FIFO, and an internal clear sequencer that zeroes registers 0x00–0x18. The block sits between the C64 bus decode and the sid8580 `we/addr/data_in` inputs. It paces non-CPU writes to at most one per `ce_1m` period.

## Interface

Clock and reset: `reset` is synchronous and active-high; the clock is `clk`.

Parameters:
- `FIFO_DEPTH`, default 4. Host write FIFO entries; must be a power of two, minimum 2.
- `NUM_REGS`, default 25. Number of registers the clear sequence writes (addresses 0 … NUM_REGS-1).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `ce_1m`  in  1  1 MHz clock enable, single-cycle pulse
- `cpu_we`  in  1  CPU write strobe, single cycle
- `cpu_addr`  in  5  CPU register address
- `cpu_data`  in  8  CPU write data
- `host_valid`  in  1  host write request
- `host_ready`  out  1  FIFO can accept an entry
- `host_addr`  in  5  host register address
- `host_data`  in  8  host write data
- `clear`  in  1  pulse that starts the zero-fill sequence
- `sid_we`  out  1  registered write strobe to the SID
- `sid_addr`  out  5  SID address (write address, or `cpu_addr` when idle)
- `sid_data`  out  8  registered write data
- `busy`  out  1  clear in progress or FIFO non-empty

## Operation

States:
- **IDLE**: FIFO issue is allowed.
- **CLEAR**: the register counter `clr_idx` counts from 0 to NUM_REGS-1.
- Transitions:
  - IDLE→CLEAR on `clear`.
  - CLEAR→IDLE on the cycle the write of index NUM_REGS-1 is issued.
  - `clear` while already in CLEAR resets `clr_idx` to 0 and stays in CLEAR.

Priority per cycle, highest first:
1. CPU write (`cpu_we`). Issued in any cycle, independent of `ce_1m` and of state.
2. Clear write. Only in CLEAR, only on a `ce_1m` cycle, and only when `cpu_we`=0. Writes address `clr_idx` with data 0x00, then increments `clr_idx`.
3. FIFO write. Only in IDLE, only on a `ce_1m` cycle, only when `cpu_we`=0 and the FIFO is non-empty. Pops the head entry and writes it.

A lower-priority source that loses arbitration keeps its state: `clr_idx` is unchanged, and the FIFO head is not popped. It retries on the next `ce_1m`.

FIFO behaviour:
- Push occurs on `host_valid & host_ready`.
- `host_ready` = !full. It does not depend on the same-cycle pop, so a full FIFO refuses pushes even in a pop cycle.
- Push and pop in the same cycle leave the count unchanged.
- The FIFO is frozen (no pops) during CLEAR. Pushes are still accepted while not full.

Other rules:
- `busy` = (state==CLEAR) | (count≠0), combinational from registers.
- `sid_addr` mux:
  - Equals the issued write address in the cycle `sid_we`=1.
  - Otherwise equals `cpu_addr` combinationally, so CPU reads of 0x19–0x1C and last-write readback pass through.
- Addresses are 5-bit. Host addresses ≥ NUM_REGS are written unchanged, with no filtering.

Reset:
- state=IDLE, `clr_idx`=0, FIFO empty.
- `sid_we`=0, `sid_data`=0x00, `host_ready`=1, `busy`=0.
- Reset mid-CLEAR or with FIFO entries pending discards all pending work, with no trailing write.

## Timing

- Issue decision made in cycle N gives `sid_we`=1 in cycle N+1. Latency is exactly 1 for every source.
- `sid_we` is high for exactly one cycle per issued write.
- Two CPU writes in consecutive cycles produce two consecutive `sid_we` pulses.
- Non-CPU write rate: at most one per `ce_1m` period.
- Full clear with no CPU contention takes NUM_REGS `ce_1m` pulses from the first `ce_1m` after `clear`.
- FIFO push-to-issue: at least 1 cycle (a push in cycle N becomes visible at the head in cycle N+1), plus the wait for the next `ce_1m`.

## Structure

- Shared package `sid_ctrl_pkg` holds:
  - the state enum (IDLE, CLEAR);
  - the register-count constant 25;
  - the address/data width constants (5, 8), reusable by sid8580 wrappers.
- One sub-module, `sid_wr_fifo`: a synchronous FIFO of FIFO_DEPTH × 13 bits with full, empty and count outputs and first-word fall-through head.
- The top level holds the arbiter, the CLEAR FSM and the output registers.

## Test plan

- **CPU write passthrough:** `cpu_we`=1, addr 0x04, data 0x41 at cycle N → `sid_we`=1, `sid_addr`=0x04, `sid_data`=0x41 at N+1. `sid_addr` follows `cpu_addr` at other times.
- **FIFO pacing:** push 4 host writes (0x00←0x11, 0x01←0x22, 0x02←0x33, 0x03←0x44) back-to-back → `host_ready`=0 after the 4th. Writes appear in order, one per `ce_1m`, each exactly 1 cycle after that `ce_1m`. `busy` drops after the last write.
- **Collision:** `cpu_we` on the same cycle as `ce_1m` with the FIFO non-empty → only the CPU write is issued. The FIFO head is issued on the next `ce_1m`, and the count decrements only then.
- **Clear sequence:** pulse `clear` → 25 writes of 0x00 to addresses 0x00..0x18, one per `ce_1m`. Host entries pushed mid-clear are issued only after address 0x18.
- **Clear restart and CPU preemption:** pulse `clear` again after the write to 0x0A → sequence restarts at 0x00. A CPU write during a clear `ce_1m` cycle is issued instead, and that `clr_idx` is retried.
- **Reset mid-operation:** assert `reset` during CLEAR with 3 FIFO entries pending → next cycle `sid_we`=0, `busy`=0, `host_ready`=1. No further writes until new stimulus.
